// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the convolution pixel feeder.
package conv_pkg;

   localparam int unsigned PIX_W   = 8;
   localparam int unsigned K_W     = 16;
   localparam int unsigned K_N     = 9;
   localparam int unsigned IMG_W   = 28;
   localparam int unsigned IMG_H   = 28;
   localparam int unsigned IMG_PIX = IMG_W * IMG_H;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      STREAM   = 3'd1,
      GAP      = 3'd2,
      WAIT_FIN = 3'd3,
      DONE     = 3'd4
   } feeder_state_t;

endpackage

// File: rtl/conv_pixel_feeder_pix_ram.sv
// Image buffer: one write port, one read port, registered read data.
module pix_ram #(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem [DEPTH];

   // Contents are not reset; the host reloads the image before each use.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_o <= mem[raddr_i];
      end
   end

endmodule

// File: rtl/conv_pixel_feeder.sv
// Holds one image and a 3x3 kernel, streams the image row-major to the filter
// and waits for its completion handshake (with timeout) before signalling done.
module conv_pixel_feeder #(
   parameter int unsigned IMG_W   = conv_pkg::IMG_W,
   parameter int unsigned IMG_H   = conv_pkg::IMG_H,
   parameter int unsigned PIX_W   = conv_pkg::PIX_W,
   parameter int unsigned K_W     = conv_pkg::K_W,
   parameter int unsigned K_N     = conv_pkg::K_N,
   parameter int unsigned GAP     = 0,
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            wr_en_i,
   input  logic [$clog2(IMG_W*IMG_H)-1:0]  wr_addr_i,
   input  logic [PIX_W-1:0]                wr_data_i,
   input  logic                            k_wr_en_i,
   input  logic [K_W-1:0]                  k_data_i,
   input  logic                            start_i,
   output logic                            busy_o,
   output logic                            done_o,
   output logic                            err_o,
   output logic [K_W*K_N-1:0]              k_val_o,
   output logic [PIX_W-1:0]                pixel_o,
   output logic                            pix_data_valid_o,
   input  logic                            conv_finished_i
);

   import conv_pkg::*;

   localparam int unsigned N_PIX    = IMG_W * IMG_H;
   localparam int unsigned AW       = $clog2(N_PIX);
   localparam int unsigned GCW      = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int unsigned WCW      = $clog2(TIMEOUT + 1);
   localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

   feeder_state_t    state_q, state_d;
   logic [AW-1:0]    rd_addr_q, rd_addr_d;
   logic [GCW-1:0]   gap_q, gap_d;
   logic [WCW-1:0]   wcnt_q, wcnt_d;
   logic             err_d;
   logic             busy_d, done_d;
   logic             rd_en_c, ram_we_c, k_shift_c, drain_c;
   logic             rd_vld_q;
   logic [PIX_W-1:0] ram_rdata;

   pix_ram #(
      .DW   (PIX_W),
      .DEPTH(N_PIX),
      .AW   (AW)
   ) u_ram (
      .clk_i  (clk_i),
      .we_i   (ram_we_c),
      .waddr_i(wr_addr_i),
      .wdata_i(wr_data_i),
      .re_i   (rd_en_c),
      .raddr_i(rd_addr_q),
      .rdata_o(ram_rdata)
   );

   // Read data still in flight; the completion timeout starts only once it drains.
   assign drain_c = rd_vld_q | pix_data_valid_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         rd_addr_q <= '0;
         gap_q     <= '0;
         wcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         rd_addr_q <= rd_addr_d;
         gap_q     <= gap_d;
         wcnt_q    <= wcnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      gap_d     = gap_q;
      wcnt_d    = wcnt_q;
      err_d     = err_o;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d   = STREAM;
               rd_addr_d = '0;
               gap_d     = '0;
               wcnt_d    = '0;
               err_d     = 1'b0;
            end
         end
         STREAM: begin
            if (rd_addr_q == AW'(N_PIX - 1)) begin
               state_d = WAIT_FIN;
               wcnt_d  = '0;
            end else begin
               rd_addr_d = rd_addr_q + AW'(1);
               if (GAP > 0) begin
                  state_d = conv_pkg::GAP;
                  gap_d   = '0;
               end
            end
         end
         conv_pkg::GAP: begin
            if (gap_q == GCW'(GAP_LAST)) begin
               state_d = STREAM;
            end else begin
               gap_d = gap_q + GCW'(1);
            end
         end
         WAIT_FIN: begin
            if (conv_finished_i) begin
               state_d = DONE;
               err_d   = 1'b0;
            end else if (!drain_c) begin
               if (wcnt_q == WCW'(TIMEOUT - 1)) begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end else begin
                  wcnt_d = wcnt_q + WCW'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      rd_en_c   = 1'b0;
      ram_we_c  = 1'b0;
      k_shift_c = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      rd_en_c   = (state_q == STREAM);
      ram_we_c  = wr_en_i && (state_q == IDLE) &&
                  ({1'b0, wr_addr_i} < (AW + 1)'(N_PIX));
      k_shift_c = k_wr_en_i && (state_q == IDLE);
      busy_d    = (state_d == STREAM) || (state_d == conv_pkg::GAP) ||
                  (state_d == WAIT_FIN);
      done_d    = (state_d == DONE);
   end

   // Two-stage pixel path: RAM read register, then the output register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_o           <= 1'b0;
         done_o           <= 1'b0;
         err_o            <= 1'b0;
         rd_vld_q         <= 1'b0;
         pix_data_valid_o <= 1'b0;
         pixel_o          <= '0;
         k_val_o          <= '0;
      end else begin
         busy_o           <= busy_d;
         done_o           <= done_d;
         err_o            <= err_d;
         rd_vld_q         <= rd_en_c;
         pix_data_valid_o <= rd_vld_q;
         if (rd_vld_q) begin
            pixel_o <= ram_rdata;
         end
         if (k_shift_c) begin
            k_val_o <= {k_val_o[K_W*(K_N-1)-1:0], k_data_i};
         end
      end
   end

endmodule
